// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage feeding the single-cycle core. Owns the fetch PC, issues one
// word request at a time to instruction memory over a valid/ready channel,
// collects the in-order variable-latency responses into a small prefetch
// FIFO (instruction + PC), and handles branch/jump redirects by flushing the
// FIFO and discarding any response that belongs to a superseded request.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset
//   imem_req_valid   request valid (held with its address until accepted)
//   imem_req_ready   memory accepts the request this cycle
//   imem_req_addr    word-aligned byte address of the request
//   imem_resp_valid  response valid (one per accepted request, in order)
//   imem_resp_data   returned instruction word
//   inst_valid       FIFO head valid
//   inst_ready       core consumes the head this cycle
//   inst             head instruction (holds last value while empty)
//   inst_pc          PC of the head instruction
//   redirect_valid   taken branch/jump, one-cycle pulse
//   redirect_pc      redirect target (low two bits ignored)
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int              XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [XLEN-1:0]  r_fetch_pc;   // next PC to request
    logic [XLEN-1:0]  r_req_addr;   // address of the current/last request
    logic             r_stale;      // outstanding/pending request is superseded
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_inst;
    logic [XLEN-1:0]  r_inst_pc;
    logic [31:0]      r_fifo_inst [FIFO_DEPTH];
    logic [XLEN-1:0]  r_fifo_pc   [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  w_redirect_pc;
    logic             w_req_fire;
    logic             w_resp_fire;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_credit;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic             w_bypass;
    logic [1:0]       w_state_nxt;

    assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_req_fire    = (r_state == ST_REQ) & imem_req_ready;
    assign w_resp_fire   = (r_state == ST_RESP) & imem_resp_valid;
    // A response is kept only if its request is still current and no
    // redirect lands in the same cycle.
    assign w_push        = w_resp_fire & ~r_stale & ~redirect_valid;
    assign w_pop         = (r_count != '0) & inst_ready;
    assign w_count_nxt   = redirect_valid ? '0
                         : r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    // Only one request is ever outstanding, and it is retired in the same
    // cycle its credit is re-evaluated, so occupancy after this edge is the
    // whole credit picture.
    assign w_credit      = (w_count_nxt < CNT_W'(FIFO_DEPTH));
    assign w_rd_ptr_nxt  = r_rd_ptr + PTR_W'(w_pop);
    // The pushed word becomes the head directly when nothing else remains.
    assign w_bypass      = w_push & ((r_count - CNT_W'(w_pop)) == '0);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (!redirect_valid && w_credit) w_state_nxt = ST_REQ;
            ST_REQ:  if (imem_req_ready)              w_state_nxt = ST_RESP;
            ST_RESP: if (imem_resp_valid)             w_state_nxt = w_credit ? ST_REQ : ST_IDLE;
            default:                                  w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control: state, PCs, stale flag
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_stale    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_pc;
            end else if (w_req_fire && !r_stale) begin
                r_fetch_pc <= r_req_addr + XLEN'(4);
            end

            // The address is latched on entry to REQ and then held until
            // acceptance, even if a redirect arrives meanwhile.
            if (w_state_nxt == ST_REQ && r_state != ST_REQ) begin
                r_req_addr <= redirect_valid ? w_redirect_pc : r_fetch_pc;
            end

            // A response retires the single outstanding request, so the
            // flag clears even when a redirect coincides with it.
            if (w_resp_fire) begin
                r_stale <= 1'b0;
            end else if (redirect_valid && (r_state == ST_REQ || r_state == ST_RESP)) begin
                r_stale <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefetch FIFO
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset; validity is tracked entirely by
    // the pointers and count, so resetting the array would only cost area.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_inst[r_wr_ptr] <= imem_resp_data;
            r_fifo_pc[r_wr_ptr]   <= r_req_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            r_count  <= w_count_nxt;
        end
    end

    // Registered head: reloaded whenever the FIFO stays non-empty, otherwise
    // it keeps the last delivered instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inst    <= '0;
            r_inst_pc <= '0;
        end else if (w_count_nxt != '0) begin
            if (w_bypass) begin
                r_inst    <= imem_resp_data;
                r_inst_pc <= r_req_addr;
            end else begin
                r_inst    <= r_fifo_inst[w_rd_ptr_nxt];
                r_inst_pc <= r_fifo_pc[w_rd_ptr_nxt];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req_valid = (r_state == ST_REQ);
    assign imem_req_addr  = r_req_addr;
    assign inst_valid     = (r_count != '0);
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed and randomized bench for instr_fetch_unit. A memory model answers
// requests with configurable latency and readiness; a stream model expects
// the delivered instructions to be consecutive words starting at the reset
// PC or the latest redirect target, with data derived from the address.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int              XLEN       = 64;
    localparam logic [XLEN-1:0] RESET_PC   = 64'h0;
    localparam int              FIFO_DEPTH = 4;

    logic            clk;
    logic            reset;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] inst_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    instr_fetch_unit #(
        .XLEN       (XLEN),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Memory model configuration and state
    int          lat_min   = 1;
    int          lat_max   = 1;
    int          ready_pct = 100;
    logic        ready_en  = 1'b0;
    logic        ready_rand = 1'b1;
    logic [31:0] data_key  = 32'h0;
    logic [63:0] pend_addr [$];
    int          pend_wait [$];

    assign imem_req_ready = ready_en & ready_rand;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[33:2] ^ data_key;
    endfunction

    // Observation state (cleared by reset)
    int          n_req = 0;
    logic [63:0] req_log   [$];
    logic [63:0] deliv_log [$];
    logic [63:0] exp_pc    = RESET_PC;
    logic        hold_pending = 1'b0;
    logic [63:0] hold_addr = '0;
    int          cyc = 0;
    int          last_deliv_cyc = 0;
    int          last_gap = 0;

    // Observe at the falling edge what the DUT will see at the next rising
    // edge, then drive the memory's responses just after that edge.
    always @(negedge clk) begin
        if (reset) begin
            pend_addr.delete();
            pend_wait.delete();
            req_log.delete();
            deliv_log.delete();
            n_req        = 0;
            exp_pc       = RESET_PC;
            hold_pending = 1'b0;
        end else begin
            if (imem_resp_valid && pend_addr.size() > 0) begin
                pend_addr.delete(0);
                pend_wait.delete(0);
            end
            if (inst_valid && inst_ready) begin
                check("deliv_pc", inst_pc, exp_pc);
                check("deliv_inst", {32'h0, inst}, {32'h0, mem_word(exp_pc)});
                deliv_log.push_back(inst_pc);
                exp_pc         = exp_pc + 64'd4;
                last_gap       = cyc - last_deliv_cyc;
                last_deliv_cyc = cyc;
            end
            if (redirect_valid) exp_pc = {redirect_pc[63:2], 2'b00};
            if (hold_pending) begin
                check("req_hold_valid", 64'(imem_req_valid), 64'd1);
                check("req_hold_addr", imem_req_addr, hold_addr);
            end
            if (imem_req_valid) check("req_align", 64'(imem_req_addr[1:0]), 64'd0);
            if (imem_req_valid && imem_req_ready) begin
                check("single_outstanding", 64'(pend_addr.size()), 64'd0);
                pend_addr.push_back(imem_req_addr);
                pend_wait.push_back(int'($urandom_range(lat_max, lat_min)) - 1);
                req_log.push_back(imem_req_addr);
                n_req++;
            end
            hold_pending = imem_req_valid && !imem_req_ready;
            hold_addr    = imem_req_addr;
        end
        cyc++;
        @(posedge clk);
        #1;
        if (reset || pend_addr.size() == 0) begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end else if (pend_wait[0] == 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(pend_addr[0]);
        end else begin
            imem_resp_valid = 1'b0;
            pend_wait[0]    = pend_wait[0] - 1;
        end
        ready_rand = ($urandom_range(99, 0) < ready_pct);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        tick(2);
    endtask

    task automatic wait_req(input int n, input string tag);
        int budget = 200;
        while (n_req < n && budget > 0) begin
            tick();
            budget--;
        end
        check(tag, 64'(n_req >= n), 64'd1);
    endtask

    task automatic wait_deliv(input int n, input string tag);
        int budget = 200;
        while (deliv_log.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        check(tag, 64'(deliv_log.size() >= n), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed and random sequence
    // ------------------------------------------------------------------
    initial begin
        reset           = 1'b1;
        inst_ready      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        tick(2);

        // Reset values
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst", 64'(inst), 64'd0);
        check("rst_inst_pc", inst_pc, 64'd0);

        // Start-up latency and basic stream
        ready_en   = 1'b1;
        inst_ready = 1'b1;
        reset      = 1'b0;
        check("c0_req_valid", 64'(imem_req_valid), 64'd0);
        tick();
        check("c1_req_valid", 64'(imem_req_valid), 64'd1);
        check("c1_req_addr", imem_req_addr, RESET_PC);
        tick();
        check("c2_req_valid", 64'(imem_req_valid), 64'd0);
        check("c2_inst_valid", 64'(inst_valid), 64'd0);
        tick();
        check("c3_inst_valid", 64'(inst_valid), 64'd1);
        check("c3_inst_pc", inst_pc, 64'd0);
        check("c3_inst", 64'(inst), 64'd0);
        wait_deliv(4, "t1_deliv_timeout");
        check("t1_pc3", deliv_log[3], 64'hC);
        check("t1_gap", 64'(last_gap), 64'd2);

        // Back-pressure: FIFO fills, fetching stops, then resumes
        do_reset();
        reset = 1'b0;
        tick(20);
        check("t2_n_req", 64'(n_req), 64'd4);
        check("t2_req3_addr", req_log[3], 64'hC);
        check("t2_req_valid_low", 64'(imem_req_valid), 64'd0);
        check("t2_inst_valid", 64'(inst_valid), 64'd1);
        check("t2_head_pc", inst_pc, 64'd0);
        inst_ready = 1'b1;
        wait_deliv(4, "t2_deliv_timeout");
        check("t2_drain_pc3", deliv_log[3], 64'hC);
        wait_req(5, "t2_resume_timeout");
        check("t2_resume_addr", req_log[4], 64'h10);

        // Redirect while a request is stalled in the request channel
        do_reset();
        reset = 1'b0;
        wait_req(2, "t3_req_timeout");
        ready_en = 1'b0;
        tick(4);
        check("t3_pending_valid", 64'(imem_req_valid), 64'd1);
        check("t3_pending_addr", imem_req_addr, 64'h8);
        check("t3_buffered", 64'(inst_valid), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h40;
        tick();
        redirect_valid = 1'b0;
        check("t3_flushed", 64'(inst_valid), 64'd0);
        check("t3_hold_addr", imem_req_addr, 64'h8);
        tick(3);
        check("t3_hold_addr_late", imem_req_addr, 64'h8);
        check("t3_hold_valid_late", 64'(imem_req_valid), 64'd1);
        ready_en   = 1'b1;
        inst_ready = 1'b1;
        wait_req(4, "t3_redir_req_timeout");
        check("t3_redir_addr", req_log[3], 64'h40);
        wait_deliv(1, "t3_deliv_timeout");
        check("t3_first_pc", deliv_log[0], 64'h40);

        // Redirect during an outstanding response with 3 entries buffered
        do_reset();
        lat_min = 3;
        lat_max = 3;
        reset   = 1'b0;
        wait_req(4, "t4_req_timeout");
        check("t4_buffered", 64'(inst_valid), 64'd1);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h103;
        tick();
        redirect_valid = 1'b0;
        check("t4_flushed", 64'(inst_valid), 64'd0);
        check("t4_head_held", inst_pc, 64'd0);
        inst_ready = 1'b1;
        wait_req(5, "t4_redir_req_timeout");
        check("t4_redir_addr", req_log[4], 64'h100);
        wait_deliv(1, "t4_deliv_timeout");
        check("t4_first_pc", deliv_log[0], 64'h100);

        // Redirect to the top of the address space, fetch wraps to zero
        do_reset();
        lat_min        = 1;
        lat_max        = 1;
        inst_ready     = 1'b1;
        reset          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick(3);
        check("t5_c4_valid", 64'(inst_valid), 64'd1);
        check("t5_c4_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check("t5_c5_empty", 64'(inst_valid), 64'd0);
        check("t5_c5_pc_held", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("t5_c5_inst_held", 64'(inst), 64'hFFFF_FFFF);
        wait_req(2, "t5_req_timeout");
        check("t5_req0", req_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
        check("t5_req1", req_log[1], 64'h0);
        wait_deliv(2, "t5_deliv_timeout");
        check("t5_deliv1", deliv_log[1], 64'h0);

        // Asynchronous reset in the middle of a response wait
        do_reset();
        data_key       = 32'hA5A5_0000;
        lat_min        = 3;
        lat_max        = 3;
        reset          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        tick();
        redirect_valid = 1'b0;
        wait_req(3, "t6_req_timeout");
        check("t6_buffered", 64'(inst_valid), 64'd1);
        check("t6_head_pc", inst_pc, 64'h200);
        reset = 1'b1;
        #1;
        check("t6_rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("t6_rst_req_addr", imem_req_addr, RESET_PC);
        check("t6_rst_inst_valid", 64'(inst_valid), 64'd0);
        check("t6_rst_inst", 64'(inst), 64'd0);
        check("t6_rst_inst_pc", inst_pc, 64'd0);
        tick(2);
        data_key   = 32'h0;
        lat_min    = 1;
        lat_max    = 1;
        inst_ready = 1'b1;
        reset      = 1'b0;
        wait_req(1, "t6_after_req_timeout");
        check("t6_after_addr", req_log[0], RESET_PC);
        wait_deliv(1, "t6_after_deliv_timeout");
        check("t6_after_pc", deliv_log[0], RESET_PC);

        // Random traffic: stalls on both sides, random latency, redirects
        do_reset();
        data_key  = $urandom;
        lat_min   = 1;
        lat_max   = 3;
        ready_pct = 60;
        reset     = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            inst_ready     = ($urandom_range(3, 0) != 0);
            redirect_valid = ($urandom_range(19, 0) == 0);
            redirect_pc    = {$urandom, $urandom};
            tick();
        end
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        ready_pct      = 100;
        tick(20);
        check("t7_progress", 64'(deliv_log.size() > 50), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the single-cycle core `main`; it supplies that core's `instruction` input.
- Owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel with variable-latency responses.
- Buffers returned instructions with their PCs in a small prefetch FIFO.
- Accepts branch/jump redirects from the core, flushing buffered and in-flight fetches.

Parameters:
- XLEN, 64: PC/address width.
- RESET_PC, 0: fetch PC after reset.
- FIFO_DEPTH, 4: prefetch entries; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  XLEN  byte address of the requested word; always has bits [1:0] = 0.
- imem_resp_valid  input  1  response data valid; exactly one response per accepted request, in order, no earlier than the cycle after acceptance.
- imem_resp_data  input  32  fetched instruction word.
- inst_valid  output  1  FIFO head valid.
- inst_ready  input  1  core consumes the head.
- inst  output  32  head instruction.
- inst_pc  output  XLEN  PC of the head instruction.
- redirect_valid  input  1  taken branch/jump; one-cycle pulse.
- redirect_pc  input  XLEN  redirect target.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - fetch_pc = RESET_PC; FIFO empty; state IDLE; stale flag 0.
  - Outputs: imem_req_valid = 0, imem_req_addr = RESET_PC, inst_valid = 0, inst = 0, inst_pc = 0.
  - Reset mid-transaction abandons any outstanding request. The bench's memory model must also reset.
- Credit rule: a request may start only if occupancy + outstanding < FIFO_DEPTH. Outstanding is 0 or 1 (single outstanding request), so a response is never dropped for lack of space.
- State machine:
  - IDLE → REQ when credit is available and redirect_valid = 0.
  - REQ: imem_req_valid = 1 and imem_req_addr = fetch_pc, both held stable until imem_req_ready = 1. On acceptance: fetch_pc += 4 (modulo 2^XLEN, wraps silently), go to RESP.
  - RESP: wait for imem_resp_valid.
    - If stale = 0: push {imem_resp_data, pc of that request}.
    - If stale = 1: discard the data and clear stale.
    - Next state is REQ if credit is available after the push, otherwise IDLE.
- Redirect (redirect_valid = 1), highest priority:
  - FIFO flushed at the next edge, so inst_valid = 0 the following cycle.
  - fetch_pc = redirect_pc with bits [1:0] forced to 0.
  - In REQ: the pending request stays asserted and unchanged until accepted (no retraction). Stale is set, the state moves to RESP on acceptance, and that response is dropped.
  - In RESP: stale is set, and a response arriving in the same cycle is dropped.
  - In IDLE: no stale marking.
  - A redirect in the same cycle as an inst handshake: the pop still counts as consumed, and the flush wins for the remaining entries.
  - A redirect in the same cycle as a non-stale response: the response is dropped.
- FIFO and output:
  - inst_valid = !empty; inst and inst_pc are driven from the registered head.
  - Pop on inst_valid & inst_ready; push and pop in the same cycle are allowed, including at full.
  - Pointers wrap modulo FIFO_DEPTH.
  - inst and inst_pc hold their last value while empty.
- Latency with an always-ready memory and next-cycle response:
  - First imem_req_valid in cycle 1 after reset release; accepted cycle 1; response cycle 2; inst_valid cycle 3.
  - Steady state: one instruction every 2 cycles.

Test Plan:
- Reset release, ready = 1, response after 1 cycle, inst_ready = 1, memory word i = i → inst_pc 0, 4, 8, 12 with inst 0, 1, 2, 3; first inst_valid 3 cycles after release.
- inst_ready = 0 for 20 cycles → exactly 4 requests issued (addresses 0–12), imem_req_valid low thereafter, FIFO full. Raise inst_ready → entries 0–12 drain in order, fetching resumes at 0x10.
- imem_req_ready = 0 with the request at 0x8 pending, redirect to 0x40 → addr stays 0x8 until accepted, its response is dropped, next request is 0x40, first delivered inst_pc = 0x40.
- Redirect to 0x103 during RESP with 3 entries buffered → inst_valid low the next cycle, buffered entries gone, next request addr 0x100.
- Redirect to 0xFFFFFFFFFFFFFFFC → requests 0xFFFFFFFFFFFFFFFC then 0x0.
- Assert reset while in RESP with 2 entries buffered → outputs return to reset values immediately; after release, the first request addr = RESET_PC.
